// File: rtl/watpixels_pkg.sv
// ============================================================================
// Module   : watpixels_pkg
// Brief    : Shared speed encoding constants and ui_in bit map.
// Revision : 1.0
// ============================================================================
`default_nettype none

package watpixels_pkg;

  localparam int SPEED_W = 3;

  typedef logic [SPEED_W-1:0] speed_t;

  localparam speed_t SPEED_MIN = 3'd1;
  localparam speed_t SPEED_MAX = 3'd6;

  localparam int IDX_PAUSE   = 0;
  localparam int IDX_RESUME  = 1;
  localparam int IDX_SPEED_1 = 2;
  localparam int IDX_SPEED_2 = 3;
  localparam int IDX_SPEED_3 = 4;
  localparam int IDX_SPEED_4 = 5;
  localparam int IDX_SPEED_5 = 6;
  localparam int IDX_SPEED_6 = 7;

  // speed_1 is implied when nothing higher is held, so its bit is never read
  function automatic speed_t encode_speed(input logic [7:0] i_deb);
    if (i_deb[IDX_SPEED_6])      return SPEED_MAX;
    else if (i_deb[IDX_SPEED_5]) return 3'd5;
    else if (i_deb[IDX_SPEED_4]) return 3'd4;
    else if (i_deb[IDX_SPEED_3]) return 3'd3;
    else if (i_deb[IDX_SPEED_2]) return 3'd2;
    else                         return SPEED_MIN;
  endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_bit.sv
// ============================================================================
// Module   : debounce_bit
// Brief    : 2-flop synchroniser plus debounce counter for one pad input.
//            Counter built only when INPUT_DEBOUNCE_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module debounce_bit
  import watpixels_pkg::*;
#(
  parameter int DB_CYCLES = 262144
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_deb
);

  logic r_sync1;
  logic r_sync2;
  logic r_deb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

`ifdef INPUT_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // The new level must differ on DB_CYCLES consecutive cycles to be taken
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_deb <= 1'b0;
    end else if (r_sync2 != r_deb) begin
      if (r_cnt == CNT_LAST) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) r_deb <= 1'b0;
    else     r_deb <= r_sync2;
  end
`endif

  assign o_deb = r_deb;

endmodule

`default_nettype wire

// File: rtl/input_conditioner.sv
// ============================================================================
// Module   : input_conditioner
// Brief    : Debounces 8 pad inputs, derives pause/resume strobes, run state
//            and encoded speed. Debounce counters enabled by INPUT_DEBOUNCE_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module input_conditioner
  import watpixels_pkg::*;
#(
  parameter int DB_CYCLES = 262144
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         ui_in,
  output logic               pause_pulse,
  output logic               resume_pulse,
  output logic               paused,
  output logic [SPEED_W-1:0] speed,
  output logic               speed_changed
);

  logic [7:0]   w_deb;
  logic [1:0]   r_deb_d;
  logic         w_pause_rise;
  logic         w_resume_rise;
  speed_t       w_speed_enc;

  logic         r_pause_pulse;
  logic         r_resume_pulse;
  logic         r_paused;
  speed_t       r_speed;
  logic         r_speed_changed;

  for (genvar gi = 0; gi < 8; gi++) begin : g_bit
    debounce_bit #(
      .DB_CYCLES(DB_CYCLES)
    ) u_debounce_bit (
      .clk  (clk),
      .rst  (rst),
      .i_raw(ui_in[gi]),
      .o_deb(w_deb[gi])
    );
  end

  assign w_pause_rise  = w_deb[IDX_PAUSE]  & ~r_deb_d[0];
  assign w_resume_rise = w_deb[IDX_RESUME] & ~r_deb_d[1];
  assign w_speed_enc   = encode_speed(w_deb);

  // paused updates on the same edge that makes the strobe visible; pause wins
  always_ff @(posedge clk) begin
    if (rst) begin
      r_deb_d         <= 2'b00;
      r_pause_pulse   <= 1'b0;
      r_resume_pulse  <= 1'b0;
      r_paused        <= 1'b0;
      r_speed         <= SPEED_MIN;
      r_speed_changed <= 1'b0;
    end else begin
      r_deb_d         <= {w_deb[IDX_RESUME], w_deb[IDX_PAUSE]};
      r_pause_pulse   <= w_pause_rise;
      r_resume_pulse  <= w_resume_rise;
      if (w_pause_rise)       r_paused <= 1'b1;
      else if (w_resume_rise) r_paused <= 1'b0;
      r_speed         <= w_speed_enc;
      r_speed_changed <= (w_speed_enc != r_speed);
    end
  end

  assign pause_pulse   = r_pause_pulse;
  assign resume_pulse  = r_resume_pulse;
  assign paused        = r_paused;
  assign speed         = r_speed;
  assign speed_changed = r_speed_changed;

endmodule

`default_nettype wire
